audio_out_feeder: RTL and testbench

- Downstream stage of the synth ALU controller. Consumes the 32-bit signed wave_out stream and decimates it to the codec sample rate.
- Applies mute and a power-of-two volume attenuation to each sample.
- Buffers samples in a small FIFO and writes them to the DE1 audio codec core using its allowed/write handshake.
- The same sample is sent to both the left and right channels.

---
 rtl/audio_out_feeder.sv | 135 +++++++++++++
 tb/tb_audio_out_feeder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_out_feeder.sv
// Decimates the ALU wave stream to the codec sample rate, applies mute/volume,
// buffers samples in a small FIFO and drives the codec allowed/write handshake.
module audio_out_feeder #(
  parameter int SAMPLE_DIV = 1042,
  parameter int DEPTH      = 8,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          mute,
  input  logic [2:0]    volume,
  input  logic [31:0]   wave_in,
  input  logic          clear_flags,
  input  logic          audio_out_allowed,
  output logic [31:0]   left_channel_audio_out,
  output logic [31:0]   right_channel_audio_out,
  output logic          write_audio_out,
  output logic          sample_tick,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [31:0]        sample_q, sample_d;
  logic               write_q, write_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        mem_q [DEPTH];

  logic               tick;
  logic               pop;
  logic               push;
  logic               drop;
  logic signed [31:0] shifted;
  logic [31:0]        captured;

  always_comb begin
    tick       = enable && (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_cnt_q;
    if (enable) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    shifted  = $signed(wave_in) >>> volume;
    captured = mute ? 32'd0 : shifted;

    // A full FIFO still accepts a sample when the FSM pops in the same cycle.
    pop  = (state_q == IDLE) && (count_q != '0) && audio_out_allowed;
    push = tick && ((count_q < FULL_COUNT) || pop);
    drop = tick && !push;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_flags) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    state_d  = state_q;
    sample_d = sample_q;
    write_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          sample_d = mem_q[rd_ptr_q];
          write_d  = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sample_q   <= '0;
      write_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sample_q   <= sample_d;
      write_q    <= write_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= captured;
    end
  end

  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;
  assign write_audio_out         = write_q;
  assign sample_tick             = tick;
  assign fifo_count              = count_q;
  assign overflow                = overflow_q;

endmodule

// File: tb/tb_audio_out_feeder.sv
// Bench for audio_out_feeder: directed scenarios plus random traffic, checked
// against a queue-based sample-flow model.
module tb_audio_out_feeder;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          mute;
  logic [2:0]    volume;
  logic [31:0]   wave_in;
  logic          clear_flags;
  logic          audio_out_allowed;
  logic [31:0]   left_channel_audio_out;
  logic [31:0]   right_channel_audio_out;
  logic          write_audio_out;
  logic          sample_tick;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  audio_out_feeder #(.SAMPLE_DIV(DIV), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .mute                    (mute),
    .volume                  (volume),
    .wave_in                 (wave_in),
    .clear_flags             (clear_flags),
    .audio_out_allowed       (audio_out_allowed),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .write_audio_out         (write_audio_out),
    .sample_tick             (sample_tick),
    .fifo_count              (fifo_count),
    .overflow                (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: buffered samples, the sample currently on the codec bus,
  // whether a strobe is in flight this cycle, the sticky flag and the divider phase.
  logic [31:0] exp_q[$];
  logic [31:0] m_last = '0;
  bit          m_busy = 1'b0;
  bit          m_ovf  = 1'b0;
  int          m_cnt  = 0;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] scale(input logic [31:0] w, input logic [2:0] vol, input logic m);
    longint v, d, q;
    v = longint'($signed(w));
    d = longint'(1) << vol;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return m ? 32'd0 : q[31:0];
  endfunction

  // Advances DUT and model by one clock; returns just after the following negedge.
  task automatic step();
    bit pop, tick;
    if (reset) begin
      exp_q.delete();
      m_last = '0;
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
    end else begin
      pop  = !m_busy && (exp_q.size() != 0) && audio_out_allowed;
      tick = enable && (m_cnt == DIV - 1);
      if (pop) m_last = exp_q.pop_front();
      if (tick && exp_q.size() < DEPTH) exp_q.push_back(scale(wave_in, volume, mute));
      if (tick && exp_q.size() >= DEPTH && !pop && m_ovf_drop(pop)) m_ovf = 1'b1;
      else if (clear_flags) m_ovf = 1'b0;
      m_busy = pop;
      if (enable) m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drop bookkeeping lives apart from the push so the decision is made on the pre-push state.
  bit drop_now;
  function automatic bit m_ovf_drop(input bit pop);
    return drop_now && !pop;
  endfunction

  task automatic step_sample();
    drop_now = !reset && enable && (m_cnt == DIV - 1) &&
               (exp_q.size() >= DEPTH) && !(!m_busy && exp_q.size() != 0 && audio_out_allowed);
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; mute = 1'b0; volume = '0; wave_in = '0;
    clear_flags = 1'b0; audio_out_allowed = 1'b0;
    step_sample();
    step_sample();
    reset = 1'b0;
    n_vec++; if (write_audio_out !== 1'b0) begin n_err++; $display("FAIL reset_write: got %b want 0", write_audio_out); end
    n_vec++; if (left_channel_audio_out !== 32'd0 || right_channel_audio_out !== 32'd0) begin
      n_err++; $display("FAIL reset_channels: got %h/%h want 0", left_channel_audio_out, right_channel_audio_out); end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_vec++; if (sample_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", sample_tick); end
  endtask

  task automatic test_basic_stream();
    int cyc, tick_cyc;
    enable = 1'b1; audio_out_allowed = 1'b1; wave_in = 32'h0000_1000; volume = 3'd0; mute = 1'b0;
    cyc = 0; tick_cyc = -100;
    for (int i = 0; i < 24; i++) begin
      if (m_cnt == DIV - 1) tick_cyc = cyc;
      step_sample();
      cyc++;
      n_vec++;
      if (sample_tick !== (enable && m_cnt == DIV - 1) || write_audio_out !== m_busy ||
          left_channel_audio_out !== m_last || right_channel_audio_out !== m_last ||
          fifo_count !== 3'(exp_q.size()) || overflow !== m_ovf) begin
        n_err++;
        $display("FAIL basic_model cyc %0d: tick=%b wr=%b l=%h r=%h cnt=%0d ovf=%b want tick=%b wr=%b data=%h cnt=%0d ovf=%b",
                 cyc, sample_tick, write_audio_out, left_channel_audio_out, right_channel_audio_out, fifo_count, overflow,
                 (enable && m_cnt == DIV - 1), m_busy, m_last, exp_q.size(), m_ovf);
      end
      n_vec++;
      if (fifo_count > 3'd1) begin n_err++; $display("FAIL basic_depth: got %0d want <=1", fifo_count); end
      if (write_audio_out === 1'b1) begin
        n_vec++;
        if (cyc - tick_cyc != 2 || left_channel_audio_out !== 32'h0000_1000) begin
          n_err++;
          $display("FAIL basic_latency: got %0d cycles data %h want 2 cycles data 00001000", cyc - tick_cyc, left_channel_audio_out);
        end
      end
    end
  endtask

  task automatic test_volume_mute();
    wave_in = 32'hFFFF_F000; volume = 3'd3;
    for (int i = 0; i < 12; i++) step_sample();
    n_vec++;
    if (left_channel_audio_out !== 32'hFFFF_FE00 || right_channel_audio_out !== 32'hFFFF_FE00) begin
      n_err++; $display("FAIL volume_shift: got %h/%h want fffffe00", left_channel_audio_out, right_channel_audio_out);
    end
    mute = 1'b1;
    for (int i = 0; i < 12; i++) step_sample();
    n_vec++;
    if (left_channel_audio_out !== 32'd0 || right_channel_audio_out !== 32'd0) begin
      n_err++; $display("FAIL mute: got %h/%h want 0", left_channel_audio_out, right_channel_audio_out);
    end
    mute = 1'b0; volume = 3'd0;
  endtask

  task automatic test_backpressure();
    int k, guard, cyc;
    logic [31:0] got[$];
    int gcyc[$];
    enable = 1'b0; audio_out_allowed = 1'b1;
    for (int i = 0; i < 6; i++) step_sample();
    enable = 1'b1; audio_out_allowed = 1'b0;
    k = 0; guard = 0;
    while (k < 6 && guard < 100) begin
      bit t;
      wave_in = 32'(k + 1);
      t = (m_cnt == DIV - 1);
      step_sample();
      guard++;
      if (t) k++;
      n_vec++;
      if (sample_tick !== (enable && m_cnt == DIV - 1) || write_audio_out !== m_busy ||
          left_channel_audio_out !== m_last || fifo_count !== 3'(exp_q.size()) || overflow !== m_ovf) begin
        n_err++;
        $display("FAIL stall_model: tick=%b wr=%b l=%h cnt=%0d ovf=%b want tick=%b wr=%b data=%h cnt=%0d ovf=%b",
                 sample_tick, write_audio_out, left_channel_audio_out, fifo_count, overflow,
                 (enable && m_cnt == DIV - 1), m_busy, m_last, exp_q.size(), m_ovf);
      end
    end
    n_vec++; if (k < 6) begin n_err++; $display("FAIL stall_timeout: got %0d ticks want 6", k); end
    n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL stall_saturate: got %0d want 4", fifo_count); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL stall_overflow: got %b want 1", overflow); end
    enable = 1'b0; audio_out_allowed = 1'b1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      step_sample();
      cyc++;
      if (write_audio_out === 1'b1) begin got.push_back(left_channel_audio_out); gcyc.push_back(cyc); end
    end
    n_vec++;
    if (got.size() != 4) begin
      n_err++; $display("FAIL drain_count: got %0d writes want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (got[i] !== 32'(i + 1)) begin n_err++; $display("FAIL drain_order[%0d]: got %h want %h", i, got[i], 32'(i + 1)); end
        if (i > 0) begin
          n_vec++;
          if (gcyc[i] - gcyc[i-1] != 2) begin n_err++; $display("FAIL drain_spacing[%0d]: got %0d want 2", i, gcyc[i] - gcyc[i-1]); end
        end
      end
    end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL drain_empty: got %0d want 0", fifo_count); end
    clear_flags = 1'b1;
    step_sample();
    clear_flags = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clear_flags: got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    int guard;
    enable = 1'b1; audio_out_allowed = 1'b0;
    guard = 0;
    while (exp_q.size() < DEPTH && guard < 100) begin
      wave_in = $urandom;
      step_sample();
      guard++;
    end
    while (m_cnt != DIV - 1 && guard < 100) begin step_sample(); guard++; end
    n_vec++; if (guard >= 100) begin n_err++; $display("FAIL full_timeout: got %0d cycles want <100", guard); end
    n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_setup: got %0d want 4", fifo_count); end
    audio_out_allowed = 1'b1;
    wave_in = $urandom;
    step_sample();
    n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_pushpop_count: got %0d want 4", fifo_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pushpop_overflow: got %b want 0", overflow); end
    n_vec++; if (write_audio_out !== 1'b1) begin n_err++; $display("FAIL full_pushpop_write: got %b want 1", write_audio_out); end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_sample();
      n_vec++;
      if (write_audio_out !== m_busy || left_channel_audio_out !== m_last || fifo_count !== 3'(exp_q.size())) begin
        n_err++;
        $display("FAIL full_drain: wr=%b l=%h cnt=%0d want wr=%b data=%h cnt=%0d",
                 write_audio_out, left_channel_audio_out, fifo_count, m_busy, m_last, exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int guard;
    enable = 1'b1; audio_out_allowed = 1'b0; guard = 0;
    while (exp_q.size() < DEPTH && guard < 100) begin wave_in = $urandom; step_sample(); guard++; end
    enable = 1'b0; audio_out_allowed = 1'b1;
    step_sample();
    n_vec++;
    if (write_audio_out !== 1'b1 || fifo_count !== 3'd3) begin
      n_err++; $display("FAIL midreset_setup: wr=%b cnt=%0d want wr=1 cnt=3", write_audio_out, fifo_count);
    end
    reset = 1'b1;
    step_sample();
    reset = 1'b0;
    n_vec++;
    if (write_audio_out !== 1'b0 || left_channel_audio_out !== 32'd0 || right_channel_audio_out !== 32'd0 ||
        fifo_count !== 3'd0 || overflow !== 1'b0 || sample_tick !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: wr=%b l=%h r=%h cnt=%0d ovf=%b tick=%b want all 0",
               write_audio_out, left_channel_audio_out, right_channel_audio_out, fifo_count, overflow, sample_tick);
    end
    for (int i = 0; i < 8; i++) begin
      step_sample();
      n_vec++;
      if (write_audio_out !== 1'b0 || fifo_count !== 3'd0) begin
        n_err++; $display("FAIL midreset_quiet: wr=%b cnt=%0d want 0/0", write_audio_out, fifo_count);
      end
    end
  endtask

  task automatic test_enable_hold();
    enable = 1'b1; audio_out_allowed = 1'b1;
    step_sample();
    step_sample();
    enable = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (sample_tick !== 1'b0) begin n_err++; $display("FAIL hold_tick[%0d]: got %b want 0", i, sample_tick); end
      step_sample();
    end
    enable = 1'b1;
    #1;
    n_vec++; if (sample_tick !== 1'b0) begin n_err++; $display("FAIL resume_early: got %b want 0", sample_tick); end
    step_sample();
    n_vec++; if (sample_tick !== 1'b1) begin n_err++; $display("FAIL resume_tick: got %b want 1", sample_tick); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      enable            = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) audio_out_allowed = ~audio_out_allowed;
      mute              = ($urandom_range(0, 7) == 0);
      volume            = 3'($urandom_range(0, 7));
      wave_in           = $urandom;
      clear_flags       = ($urandom_range(0, 15) == 0);
      reset             = ($urandom_range(0, 249) == 0);
      step_sample();
      n_vec++;
      if (sample_tick !== (enable && m_cnt == DIV - 1) || write_audio_out !== m_busy ||
          left_channel_audio_out !== m_last || right_channel_audio_out !== m_last ||
          fifo_count !== 3'(exp_q.size()) || overflow !== m_ovf) begin
        n_err++;
        $display("FAIL random_model[%0d]: tick=%b wr=%b l=%h r=%h cnt=%0d ovf=%b want tick=%b wr=%b data=%h cnt=%0d ovf=%b",
                 i, sample_tick, write_audio_out, left_channel_audio_out, right_channel_audio_out, fifo_count, overflow,
                 (enable && m_cnt == DIV - 1), m_busy, m_last, exp_q.size(), m_ovf);
      end
    end
    reset = 1'b0; clear_flags = 1'b0;
  endtask

  initial begin
    drop_now = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_stream();
    test_volume_mute();
    test_backpressure();
    test_full_push_pop();
    test_reset_mid_write();
    test_enable_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
